// File: rtl/batch_row_reader.sv
// batch_row_reader
// Consumer side of the batch buffer read conduits. It waits until both the
// data and the weight buffer hold a complete batch, then walks rows
// 0..ROWS-1. Each row pair is captured and offered to the compute array
// through a valid/ready handshake. The buffer read clock is i_clk, so the
// whole block is single-clock.

module batch_row_reader #(
  parameter int ROWS       = 8,
  parameter int ROW_W      = 3,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_data_rd_ready,
  output logic [ROW_W-1:0]  o_data_rd_row,
  input  logic [DATA_W-1:0] i_data_row,
  input  logic              i_weight_rd_ready,
  output logic [ROW_W-1:0]  o_weight_rd_row,
  input  logic [DATA_W-1:0] i_weight_row,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [DATA_W-1:0] o_weight,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_abort
);

  // The wait counter must hold RD_LATENCY; keep at least one bit so that a
  // zero-latency build still has a legal vector.
  localparam int WAIT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [ROW_W-1:0]  row;
  logic [WAIT_W-1:0] wait_cnt;

  logic both_ready;
  logic at_last_row;
  logic start_batch;
  logic abort_batch;
  logic fetch_wait;
  logic capture_row;
  logic accept_row;
  logic leave_done;

  assign both_ready      = i_data_rd_ready && i_weight_rd_ready;
  assign at_last_row     = (row == LAST_ROW);
  assign o_data_rd_row   = row;
  assign o_weight_rd_row = row;

  // State register; clearing returns to IDLE regardless of any batch in flight.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a dropped rd_ready always wins over the handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (both_ready) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (!both_ready) begin
          next_state = IDLE;
        end else if (wait_cnt == '0) begin
          next_state = PRESENT;
        end
      end
      PRESENT: begin
        if (!both_ready) begin
          next_state = IDLE;
        end else if (i_ready) begin
          next_state = at_last_row ? DONE : FETCH;
        end
      end
      DONE: begin
        if (!both_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output and strobe decode from the current state and sampled inputs.
  always_comb begin
    o_busy      = (state == FETCH) || (state == PRESENT);
    start_batch = (state == IDLE) && both_ready;
    abort_batch = o_busy && !both_ready;
    fetch_wait  = (state == FETCH) && both_ready && (wait_cnt != '0);
    capture_row = (state == FETCH) && both_ready && (wait_cnt == '0);
    accept_row  = (state == PRESENT) && both_ready && i_ready;
    leave_done  = (state == DONE) && !both_ready;
  end

  // Row and read-latency counters; the row index stops at the last row and
  // returns to 0 whenever a batch ends or is abandoned.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      row      <= '0;
      wait_cnt <= '0;
    end else begin
      if (start_batch) begin
        row      <= '0;
        wait_cnt <= WAIT_INIT;
      end
      if (fetch_wait) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (accept_row && !at_last_row) begin
        row      <= row + ROW_W'(1);
        wait_cnt <= WAIT_INIT;
      end
      if (abort_batch || leave_done) begin
        row <= '0;
      end
    end
  end

  // Captured row registers, valid flag and the one-cycle done/abort pulses.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_weight  <= '0;
      o_row_idx <= '0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      if (capture_row) begin
        o_data    <= i_data_row;
        o_weight  <= i_weight_row;
        o_row_idx <= row;
        o_last    <= at_last_row;
        o_valid   <= 1'b1;
      end
      if (accept_row) begin
        o_valid <= 1'b0;
        o_done  <= at_last_row;
      end
      if (abort_batch) begin
        o_valid <= 1'b0;
        o_abort <= 1'b1;
      end
    end
  end

endmodule
